// File: rtl/act_mem_banked_ctrl_pkg.sv
// Shared defaults, requester encoding and address helpers for the banked
// activation-memory controller.
package act_mem_pkg;

   localparam int ACT_LANES      = 4;
   localparam int ACT_LANE_W     = 8;
   localparam int ACT_BANKS      = 2;
   localparam int ACT_BANK_DEPTH = 2048;
   localparam int NUM_REQ        = 4;

   // Enum order is also the per-bank priority order (lowest value wins).
   typedef enum logic [1:0] {
      REQ_EXT_WR = 2'd0,
      REQ_INT_WR = 2'd1,
      REQ_EXT_RD = 2'd2,
      REQ_INT_RD = 2'd3
   } req_e;

   // Bank index is the top bank_w bits of an addr_w-bit row address.
   function automatic int unsigned bank_of(input logic [31:0] addr,
                                           input int addr_w,
                                           input int bank_w);
      return addr >> (addr_w - bank_w);
   endfunction

endpackage

// File: rtl/act_mem_banked_ctrl_bank.sv
// Behavioural single-port row-wide macro with per-lane write enables and
// a registered read port. Contents are never reset.
module act_mem_bank #(
   parameter int DEPTH  = 2048,
   parameter int LANES  = 4,
   parameter int LANE_W = 8,
   localparam int ROW_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    i_ce,
   input  logic                    i_we,
   input  logic [LANES-1:0]        i_mask,
   input  logic [ROW_W-1:0]        i_row,
   input  logic [LANES*LANE_W-1:0] i_d,
   output logic [LANES*LANE_W-1:0] o_q
);

   logic [LANES*LANE_W-1:0] r_mem [DEPTH];
   logic [LANES*LANE_W-1:0] r_q;

   // Masked lane write, or synchronous read into the output register.
   always_ff @(posedge clk) begin
      if (i_ce) begin
         if (i_we) begin
            for (int l = 0; l < LANES; l++)
               if (i_mask[l]) r_mem[i_row][l*LANE_W +: LANE_W] <= i_d[l*LANE_W +: LANE_W];
         end else begin
            r_q <= r_mem[i_row];
         end
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/act_mem_banked_ctrl.sv
// Four-requester banked activation memory: per-bank fixed-priority
// arbitration, optional RF region in bank 0, pipelined read return,
// internal-read row hold and a saturating stall counter.
module act_mem_banked_ctrl
   import act_mem_pkg::*;
#(
   parameter int LANES      = ACT_LANES,
   parameter int LANE_W     = ACT_LANE_W,
   parameter int BANKS      = ACT_BANKS,
   parameter int BANK_DEPTH = ACT_BANK_DEPTH,
   parameter int RF_DEPTH   = 64,
   parameter int OUT_REG    = 1,
   parameter int ADDR_W     = $clog2(BANKS*BANK_DEPTH),
   parameter int CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_ext_wr_req,
   input  logic [ADDR_W-1:0]       i_ext_wr_addr,
   input  logic [LANES*LANE_W-1:0] i_ext_wr_data,
   input  logic [LANES-1:0]        i_ext_wr_mask,
   output logic                    o_ext_wr_ready,
   input  logic                    i_int_wr_req,
   input  logic [ADDR_W-1:0]       i_int_wr_addr,
   input  logic [LANES*LANE_W-1:0] i_int_wr_data,
   input  logic [LANES-1:0]        i_int_wr_mask,
   output logic                    o_int_wr_ready,
   input  logic                    i_ext_rd_req,
   input  logic [ADDR_W-1:0]       i_ext_rd_addr,
   output logic                    o_ext_rd_ready,
   output logic                    o_ext_rd_valid,
   output logic [LANES*LANE_W-1:0] o_ext_rd_data,
   input  logic                    i_int_rd_req,
   input  logic [ADDR_W-1:0]       i_int_rd_addr,
   output logic                    o_int_rd_ready,
   output logic                    o_int_rd_valid,
   output logic [LANES*LANE_W-1:0] o_int_rd_data,
   output logic [CNT_W-1:0]        o_stall_cnt,
   input  logic                    i_stall_clr
);

   localparam int DW     = LANES*LANE_W;
   localparam int BSEL_W = $clog2(BANKS);
   localparam int ROW_W  = $clog2(BANK_DEPTH);
   localparam int RF_W   = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;

   // Requester-indexed views, index = req_e value.
   logic [NUM_REQ-1:0]             w_req, w_rdy, w_we, w_rf;
   logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr;
   logic [NUM_REQ-1:0][BSEL_W-1:0] w_bank;
   logic [NUM_REQ-1:0][LANES-1:0]  w_mask;
   logic [NUM_REQ-1:0][DW-1:0]     w_d;

   logic [BANKS-1:0]              w_bank_ce, w_bank_we;
   logic [BANKS-1:0][LANES-1:0]   w_bank_mask;
   logic [BANKS-1:0][ROW_W-1:0]   w_bank_row;
   logic [BANKS-1:0][DW-1:0]      w_bank_d, w_bank_q;
   logic                          w_rf_ce, w_rf_we;
   logic [LANES-1:0]              w_rf_mask;
   logic [RF_W-1:0]               w_rf_row;
   logic [DW-1:0]                 w_rf_d, w_rf_q;

   logic                          w_ird_hit;
   logic [DW-1:0]                 w_erd_q, w_ird_q;

   logic                          r_tag_vld;
   logic [ADDR_W-1:0]             r_tag;
   logic                          r_erd_vld, r_erd_rf, r_ird_vld, r_ird_rf, r_ird_hit;
   logic [BSEL_W-1:0]             r_erd_bank, r_ird_bank;
   logic [DW-1:0]                 r_ird_last;
   logic [CNT_W-1:0]              r_stall_cnt;

   assign w_req  = {i_int_rd_req, i_ext_rd_req, i_int_wr_req, i_ext_wr_req};
   assign w_addr = {i_int_rd_addr, i_ext_rd_addr, i_int_wr_addr, i_ext_wr_addr};
   assign w_we   = 4'b0011;
   assign w_mask = {{(2*LANES){1'b0}}, i_int_wr_mask, i_ext_wr_mask};
   assign w_d    = {{(2*DW){1'b0}}, i_int_wr_data, i_ext_wr_data};

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_dec
      assign w_bank[r] = BSEL_W'(bank_of(32'(w_addr[r]), ADDR_W, BSEL_W));
      assign w_rf[r]   = (RF_DEPTH > 0) && (w_bank[r] == '0) &&
                         (32'(w_addr[r][ROW_W-1:0]) < RF_DEPTH);
   end

   // A request loses if any higher-priority request targets the same bank.
   always_comb begin
      w_rdy = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         w_rdy[r] = w_req[r] && !reset;
         for (int h = 0; h < r; h++)
            if (w_req[h] && (w_bank[h] == w_bank[r])) w_rdy[r] = 1'b0;
      end
   end

   // A repeat internal read of the tagged row is served from the hold register.
   assign w_ird_hit = r_tag_vld && (r_tag == i_int_rd_addr);

   // Steer each granted request onto its bank macro or the RF macro.
   always_comb begin
      w_bank_ce = '0; w_bank_we = '0; w_bank_mask = '0; w_bank_row = '0; w_bank_d = '0;
      w_rf_ce = 1'b0; w_rf_we = 1'b0; w_rf_mask = '0; w_rf_row = '0; w_rf_d = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (w_rdy[r] && !((r == int'(REQ_INT_RD)) && w_ird_hit)) begin
            if (w_rf[r]) begin
               w_rf_ce   = 1'b1;
               w_rf_we   = w_we[r];
               w_rf_mask = w_mask[r];
               w_rf_row  = w_addr[r][RF_W-1:0];
               w_rf_d    = w_d[r];
            end else begin
               w_bank_ce[w_bank[r]]   = 1'b1;
               w_bank_we[w_bank[r]]   = w_we[r];
               w_bank_mask[w_bank[r]] = w_mask[r];
               w_bank_row[w_bank[r]]  = w_addr[r][ROW_W-1:0];
               w_bank_d[w_bank[r]]    = w_d[r];
            end
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      act_mem_bank #(.DEPTH(BANK_DEPTH), .LANES(LANES), .LANE_W(LANE_W)) u_bank (
         .clk(clk), .i_ce(w_bank_ce[b]), .i_we(w_bank_we[b]), .i_mask(w_bank_mask[b]),
         .i_row(w_bank_row[b]), .i_d(w_bank_d[b]), .o_q(w_bank_q[b]));
   end

   if (RF_DEPTH > 0) begin : g_rf
      act_mem_bank #(.DEPTH(RF_DEPTH), .LANES(LANES), .LANE_W(LANE_W)) u_rf (
         .clk(clk), .i_ce(w_rf_ce), .i_we(w_rf_we), .i_mask(w_rf_mask),
         .i_row(w_rf_row), .i_d(w_rf_d), .o_q(w_rf_q));
   end else begin : g_no_rf
      assign w_rf_q = '0;
   end

   // Hold tag: set by every granted int read, dropped by a write to that row.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag_vld <= 1'b0;
         r_tag     <= '0;
      end else if (w_rdy[REQ_INT_RD]) begin
         r_tag_vld <= 1'b1;
         r_tag     <= i_int_rd_addr;
      end else if ((w_rdy[REQ_EXT_WR] && (i_ext_wr_addr == r_tag)) ||
                   (w_rdy[REQ_INT_WR] && (i_int_wr_addr == r_tag))) begin
         r_tag_vld <= 1'b0;
      end
   end

   // Read stage 1: remember which macro (or the hold register) answers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_erd_vld <= 1'b0; r_erd_rf <= 1'b0; r_erd_bank <= '0;
         r_ird_vld <= 1'b0; r_ird_rf <= 1'b0; r_ird_bank <= '0; r_ird_hit <= 1'b0;
      end else begin
         r_erd_vld  <= w_rdy[REQ_EXT_RD];
         r_erd_rf   <= w_rf[REQ_EXT_RD];
         r_erd_bank <= w_bank[REQ_EXT_RD];
         r_ird_vld  <= w_rdy[REQ_INT_RD];
         r_ird_rf   <= w_rf[REQ_INT_RD];
         r_ird_bank <= w_bank[REQ_INT_RD];
         r_ird_hit  <= w_ird_hit;
      end
   end

   assign w_erd_q = r_erd_rf ? w_rf_q : w_bank_q[r_erd_bank];
   assign w_ird_q = r_ird_hit ? r_ird_last : (r_ird_rf ? w_rf_q : w_bank_q[r_ird_bank]);

   // Last int read data: doubles as row-hold data and held int output.
   always_ff @(posedge clk) begin
      if (reset)          r_ird_last <= '0;
      else if (r_ird_vld) r_ird_last <= w_ird_q;
   end

   if (OUT_REG != 0) begin : g_oreg
      logic          r_erd_vld2, r_ird_vld2;
      logic [DW-1:0] r_erd_data;
      // Extra output stage; ext data is forced to zero when not valid.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_erd_vld2 <= 1'b0; r_ird_vld2 <= 1'b0; r_erd_data <= '0;
         end else begin
            r_erd_vld2 <= r_erd_vld;
            r_ird_vld2 <= r_ird_vld;
            r_erd_data <= r_erd_vld ? w_erd_q : '0;
         end
      end
      assign o_ext_rd_valid = r_erd_vld2;
      assign o_ext_rd_data  = r_erd_data;
      assign o_int_rd_valid = r_ird_vld2;
      assign o_int_rd_data  = r_ird_last;
   end else begin : g_ocomb
      assign o_ext_rd_valid = r_erd_vld;
      assign o_ext_rd_data  = r_erd_vld ? w_erd_q : '0;
      assign o_int_rd_valid = r_ird_vld;
      assign o_int_rd_data  = r_ird_vld ? w_ird_q : r_ird_last;
   end

   // Saturating count of cycles where any requester is held off.
   always_ff @(posedge clk) begin
      if (reset || i_stall_clr)
         r_stall_cnt <= '0;
      else if ((|(w_req & ~w_rdy)) && !(&r_stall_cnt))
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign o_ext_wr_ready = w_rdy[REQ_EXT_WR];
   assign o_int_wr_ready = w_rdy[REQ_INT_WR];
   assign o_ext_rd_ready = w_rdy[REQ_EXT_RD];
   assign o_int_rd_ready = w_rdy[REQ_INT_RD];
   assign o_stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_act_mem_banked_ctrl.sv
// Directed bench for act_mem_banked_ctrl with a queue-based read scoreboard.
module tb_act_mem_banked_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_ext_wr_req, i_int_wr_req, i_ext_rd_req, i_int_rd_req, i_stall_clr;
   logic [11:0] i_ext_wr_addr, i_int_wr_addr, i_ext_rd_addr, i_int_rd_addr;
   logic [31:0] i_ext_wr_data, i_int_wr_data;
   logic [3:0]  i_ext_wr_mask, i_int_wr_mask;
   logic        o_ext_wr_ready, o_int_wr_ready, o_ext_rd_ready, o_int_rd_ready;
   logic        o_ext_rd_valid, o_int_rd_valid;
   logic [31:0] o_ext_rd_data, o_int_rd_data;
   logic [15:0] o_stall_cnt;

   typedef struct { logic [31:0] data; int due; } exp_t;
   exp_t ext_q[$];
   exp_t int_q[$];
   exp_t e_ext, e_int;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   act_mem_banked_ctrl dut (
      .clk(clk), .reset(reset),
      .i_ext_wr_req(i_ext_wr_req), .i_ext_wr_addr(i_ext_wr_addr), .i_ext_wr_data(i_ext_wr_data),
      .i_ext_wr_mask(i_ext_wr_mask), .o_ext_wr_ready(o_ext_wr_ready),
      .i_int_wr_req(i_int_wr_req), .i_int_wr_addr(i_int_wr_addr), .i_int_wr_data(i_int_wr_data),
      .i_int_wr_mask(i_int_wr_mask), .o_int_wr_ready(o_int_wr_ready),
      .i_ext_rd_req(i_ext_rd_req), .i_ext_rd_addr(i_ext_rd_addr), .o_ext_rd_ready(o_ext_rd_ready),
      .o_ext_rd_valid(o_ext_rd_valid), .o_ext_rd_data(o_ext_rd_data),
      .i_int_rd_req(i_int_rd_req), .i_int_rd_addr(i_int_rd_addr), .o_int_rd_ready(o_int_rd_ready),
      .o_int_rd_valid(o_int_rd_valid), .o_int_rd_data(o_int_rd_data),
      .o_stall_cnt(o_stall_cnt), .i_stall_clr(i_stall_clr));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Read-return monitor: data, arrival cycle, and zero ext data when idle.
   always @(negedge clk) begin
      checks++;
      if (o_ext_rd_valid) begin
         if (ext_q.size() == 0) begin
            errors++; $display("FAIL ext_rd unexpected valid: got %h @%0d, expected no valid", o_ext_rd_data, cyc);
         end else begin
            e_ext = ext_q.pop_front();
            if (o_ext_rd_data !== e_ext.data || cyc != e_ext.due) begin
               errors++;
               $display("FAIL ext_rd data: got %h @%0d, expected %h @%0d", o_ext_rd_data, cyc, e_ext.data, e_ext.due);
            end
         end
      end else if (o_ext_rd_data !== 32'h0) begin
         errors++; $display("FAIL ext_rd_data idle: got %h expected 00000000", o_ext_rd_data);
      end
      if (o_int_rd_valid) begin
         checks++;
         if (int_q.size() == 0) begin
            errors++; $display("FAIL int_rd unexpected valid: got %h @%0d, expected no valid", o_int_rd_data, cyc);
         end else begin
            e_int = int_q.pop_front();
            if (o_int_rd_data !== e_int.data || cyc != e_int.due) begin
               errors++;
               $display("FAIL int_rd data: got %h @%0d, expected %h @%0d", o_int_rd_data, cyc, e_int.data, e_int.due);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++; $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_ce(input string nm, input logic rf, input logic b0);
      chk({nm, " rf_ce"}, 64'(dut.w_rf_ce), 64'(rf));
      chk({nm, " bank0_ce"}, 64'(dut.w_bank_ce[0]), 64'(b0));
   endtask

   task automatic wr(input bit ext, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] m, input logic rf, input logic b0);
      if (ext) begin i_ext_wr_req = 1; i_ext_wr_addr = a; i_ext_wr_data = d; i_ext_wr_mask = m; end
      else     begin i_int_wr_req = 1; i_int_wr_addr = a; i_int_wr_data = d; i_int_wr_mask = m; end
      #1;
      chk(ext ? "ext_wr_ready" : "int_wr_ready", 64'(ext ? o_ext_wr_ready : o_int_wr_ready), 64'(1));
      chk_ce("wr", rf, b0);
      tick();
      i_ext_wr_req = 0; i_int_wr_req = 0;
   endtask

   task automatic rd(input bit ext, input logic [11:0] a, input logic [31:0] d,
                     input logic rf, input logic b0);
      if (ext) begin i_ext_rd_req = 1; i_ext_rd_addr = a; end
      else     begin i_int_rd_req = 1; i_int_rd_addr = a; end
      #1;
      chk(ext ? "ext_rd_ready" : "int_rd_ready", 64'(ext ? o_ext_rd_ready : o_int_rd_ready), 64'(1));
      chk_ce("rd", rf, b0);
      if (ext) ext_q.push_back('{d, cyc + 2});
      else     int_q.push_back('{d, cyc + 2});
      tick();
      i_ext_rd_req = 0; i_int_rd_req = 0;
   endtask

   initial begin
      reset = 1; i_stall_clr = 0;
      i_ext_wr_req = 0; i_int_wr_req = 0; i_ext_rd_req = 0; i_int_rd_req = 0;
      i_ext_wr_addr = 0; i_int_wr_addr = 0; i_ext_rd_addr = 0; i_int_rd_addr = 0;
      i_ext_wr_data = 0; i_int_wr_data = 0; i_ext_wr_mask = 0; i_int_wr_mask = 0;

      // Reset state; ready must stay low during reset.
      i_ext_wr_req = 1;
      repeat (3) @(posedge clk);
      #2;
      chk("ext_wr_ready in reset", 64'(o_ext_wr_ready), 64'(0));
      chk("ext_rd_valid reset", 64'(o_ext_rd_valid), 64'(0));
      chk("int_rd_valid reset", 64'(o_int_rd_valid), 64'(0));
      chk("int_rd_data reset", 64'(o_int_rd_data), 64'(0));
      chk("stall_cnt reset", 64'(o_stall_cnt), 64'(0));
      i_ext_wr_req = 0;
      tick();
      reset = 0;
      tick();

      // Write then read row 5 (RF region), two-cycle latency.
      wr(0, 12'd5, 32'h04030201, 4'hF, 1, 0);
      rd(0, 12'd5, 32'h04030201, 1, 0);

      // Different banks in the same cycle are both granted.
      wr(1, 12'd3000, 32'hCAFEBABE, 4'hF, 0, 0);
      i_ext_wr_req = 1; i_ext_wr_addr = 12'd10; i_ext_wr_data = 32'h11223344; i_ext_wr_mask = 4'hF;
      i_int_rd_req = 1; i_int_rd_addr = 12'd3000;
      #1;
      chk("t2 ext_wr_ready", 64'(o_ext_wr_ready), 64'(1));
      chk("t2 int_rd_ready", 64'(o_int_rd_ready), 64'(1));
      chk_ce("t2", 1, 0);
      int_q.push_back('{32'hCAFEBABE, cyc + 2});
      tick();
      i_ext_wr_req = 0; i_int_rd_req = 0;
      chk("t2 stall_cnt", 64'(o_stall_cnt), 64'(0));

      // ext_rd and int_rd to bank 0: ext first, int one cycle later.
      i_ext_rd_req = 1; i_ext_rd_addr = 12'd10;
      i_int_rd_req = 1; i_int_rd_addr = 12'd5;
      #1;
      chk("t3 ext_rd_ready", 64'(o_ext_rd_ready), 64'(1));
      chk("t3 int_rd_ready lose", 64'(o_int_rd_ready), 64'(0));
      ext_q.push_back('{32'h11223344, cyc + 2});
      tick();
      i_ext_rd_req = 0;
      #1;
      chk("t3 int_rd_ready retry", 64'(o_int_rd_ready), 64'(1));
      int_q.push_back('{32'h04030201, cyc + 2});
      tick();
      i_int_rd_req = 0;
      chk("t3 stall_cnt", 64'(o_stall_cnt), 64'(1));

      // RF vs SRAM routing, back-to-back reads.
      wr(0, 12'd3,   32'hA5A5A5A5, 4'hF, 1, 0);
      wr(1, 12'd100, 32'h5A5A0F0F, 4'hF, 0, 1);
      rd(1, 12'd3,   32'hA5A5A5A5, 1, 0);
      rd(1, 12'd100, 32'h5A5A0F0F, 0, 1);

      // Row hold: only the first of three reads enables a macro.
      wr(0, 12'd7, 32'h44332211, 4'hF, 1, 0);
      rd(0, 12'd7, 32'h44332211, 1, 0);
      rd(0, 12'd7, 32'h44332211, 0, 0);
      rd(0, 12'd7, 32'h44332211, 0, 0);
      wr(0, 12'd7, 32'h0000AA00, 4'b0010, 1, 0);
      rd(0, 12'd7, 32'h4433AA11, 1, 0);

      // Reset one cycle after a granted read drops it.
      repeat (4) tick();
      i_ext_rd_req = 1; i_ext_rd_addr = 12'd10;
      #1;
      chk("t6 ext_rd_ready", 64'(o_ext_rd_ready), 64'(1));
      tick();
      i_ext_rd_req = 0;
      reset = 1;
      tick();
      tick();
      reset = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6 ext_rd_valid", 64'(o_ext_rd_valid), 64'(0));
         chk("t6 ext_rd_data", 64'(o_ext_rd_data), 64'(0));
         chk("t6 int_rd_valid", 64'(o_int_rd_valid), 64'(0));
         chk("t6 stall_cnt", 64'(o_stall_cnt), 64'(0));
         tick();
      end

      // Stall counter saturation and clear priority.
      i_ext_wr_req = 1; i_ext_wr_addr = 12'd0; i_ext_wr_data = 0; i_ext_wr_mask = 4'hF;
      i_int_wr_req = 1; i_int_wr_addr = 12'd1; i_int_wr_data = 0; i_int_wr_mask = 4'hF;
      #1;
      chk("t7 int_wr_ready", 64'(o_int_wr_ready), 64'(0));
      repeat (66000) tick();
      chk("t7 stall_cnt sat", 64'(o_stall_cnt), 64'(16'hFFFF));
      repeat (3) tick();
      chk("t7 stall_cnt hold", 64'(o_stall_cnt), 64'(16'hFFFF));
      i_stall_clr = 1;
      tick();
      chk("t7 stall_cnt clr", 64'(o_stall_cnt), 64'(0));
      i_stall_clr = 0; i_ext_wr_req = 0; i_int_wr_req = 0;

      // Every expected read must have returned.
      for (int i = 0; i < 20 && (ext_q.size() != 0 || int_q.size() != 0); i++) tick();
      chk("ext queue drained", 64'(ext_q.size()), 64'(0));
      chk("int queue drained", 64'(int_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
